// File: rtl/s2mm_ring_writer_if.sv
// AXI-Stream sink plus AXI4 write-master bundle for the S2MM ring writer.
// The master modport is the writer's side; slave is the memory/stream side.
interface s2mm_ring_writer_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 64
);
  logic                        S_AXIS_tready;
  logic [AXI_DATA_WIDTH-1:0]   S_AXIS_tdata;
  logic                        S_AXIS_tvalid;

  logic [AXI_ID_WIDTH-1:0]     M_AXI_awid;
  logic [ADDR_WIDTH-1:0]       M_AXI_awaddr;
  logic [7:0]                  M_AXI_awlen;
  logic [2:0]                  M_AXI_awsize;
  logic [1:0]                  M_AXI_awburst;
  logic [3:0]                  M_AXI_awcache;
  logic [2:0]                  M_AXI_awprot;
  logic [3:0]                  M_AXI_awuser;
  logic                        M_AXI_awvalid;
  logic                        M_AXI_awready;

  logic [AXI_DATA_WIDTH-1:0]   M_AXI_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] M_AXI_wstrb;
  logic                        M_AXI_wlast;
  logic                        M_AXI_wvalid;
  logic                        M_AXI_wready;

  logic [1:0]                  M_AXI_bresp;
  logic                        M_AXI_bvalid;
  logic                        M_AXI_bready;

  modport master (
    output S_AXIS_tready,
    input  S_AXIS_tdata, S_AXIS_tvalid,
    output M_AXI_awid, M_AXI_awaddr, M_AXI_awlen,
    output M_AXI_awsize, M_AXI_awburst, M_AXI_awcache,
    output M_AXI_awprot, M_AXI_awuser, M_AXI_awvalid,
    input  M_AXI_awready,
    output M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast,
    output M_AXI_wvalid,
    input  M_AXI_wready,
    input  M_AXI_bresp, M_AXI_bvalid,
    output M_AXI_bready
  );

  modport slave (
    input  S_AXIS_tready,
    output S_AXIS_tdata, S_AXIS_tvalid,
    input  M_AXI_awid, M_AXI_awaddr, M_AXI_awlen,
    input  M_AXI_awsize, M_AXI_awburst, M_AXI_awcache,
    input  M_AXI_awprot, M_AXI_awuser, M_AXI_awvalid,
    output M_AXI_awready,
    input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast,
    input  M_AXI_wvalid,
    output M_AXI_wready,
    output M_AXI_bresp, M_AXI_bvalid,
    input  M_AXI_bready
  );
endinterface

// File: rtl/s2mm_ring_writer.sv
// Captures an AXI-Stream into a FWFT FIFO and drains it as fixed-length
// AXI4 INCR bursts into a circular buffer in memory.
module s2mm_ring_writer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_size,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [15:0]           wrap_count,
  output logic                  overflow,
  output logic                  bresp_err,
  output logic                  busy,
  s2mm_ring_writer_if.master    bus
);
  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES =
    ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]                state;
  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [IW-1:0]             rd_idx;
  logic [IW-1:0]             wr_idx;
  logic [CW-1:0]             count;
  logic [4:0]                beat;
  logic                      enable_q;
  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      have_burst;
  logic                      rise;
  logic                      b_hs;
  logic [ADDR_WIDTH-1:0]     next_ptr;

  assign full       = count == CW'(FIFO_DEPTH);
  assign push       = bus.S_AXIS_tvalid & enable & ~full;
  assign pop        = bus.M_AXI_wvalid & bus.M_AXI_wready;
  assign have_burst = count >= CW'(BURST_LEN);
  assign rise       = enable & ~enable_q;
  assign b_hs       = (state == RESP) & bus.M_AXI_bvalid;
  assign next_ptr   = wr_ptr + BURST_BYTES;

  assign bus.S_AXIS_tready = enable;
  assign bus.M_AXI_awid    = AXI_ID_WIDTH'(0);
  assign bus.M_AXI_awaddr  = cfg_base + wr_ptr;
  assign bus.M_AXI_awlen   = 8'(BURST_LEN - 1);
  assign bus.M_AXI_awsize  = 3'($clog2(BEAT_BYTES));
  assign bus.M_AXI_awburst = 2'b01;
  assign bus.M_AXI_awcache = 4'b0011;
  assign bus.M_AXI_awprot  = 3'b000;
  assign bus.M_AXI_awuser  = 4'b0000;
  assign bus.M_AXI_awvalid = state == ADDR;
  assign bus.M_AXI_wdata   = mem[rd_idx];
  assign bus.M_AXI_wstrb   = '1;
  assign bus.M_AXI_wvalid  = state == DATA;
  assign bus.M_AXI_wlast   = (state == DATA) &&
                             (beat == 5'(BURST_LEN - 1));
  assign bus.M_AXI_bready  = state == RESP;
  assign busy              = state != IDLE;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_idx] <= bus.S_AXIS_tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bursts only start with a full burst buffered, so DATA never underruns.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      unique case (state)
        IDLE: if (enable && have_burst) state <= ADDR;
        ADDR: if (bus.M_AXI_awready) begin
          state <= DATA;
          beat  <= '0;
        end
        DATA: if (pop) begin
          beat <= beat + 1'b1;
          if (bus.M_AXI_wlast) state <= RESP;
        end
        RESP: if (bus.M_AXI_bvalid)
          state <= (enable && have_burst) ? ADDR : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      enable_q   <= 1'b0;
      wr_ptr     <= '0;
      wrap_count <= '0;
      overflow   <= 1'b0;
      bresp_err  <= 1'b0;
    end else begin
      enable_q <= enable;
      if (rise) begin
        wr_ptr     <= '0;
        wrap_count <= '0;
        overflow   <= 1'b0;
        bresp_err  <= 1'b0;
      end else begin
        if (bus.S_AXIS_tvalid && enable && full) overflow <= 1'b1;
        if (b_hs) begin
          if (bus.M_AXI_bresp != 2'b00) bresp_err <= 1'b1;
          if (next_ptr >= cfg_size) begin
            wr_ptr <= '0;
            if (wrap_count != 16'hFFFF)
              wrap_count <= wrap_count + 16'd1;
          end else begin
            wr_ptr <= next_ptr;
          end
        end
      end
    end
  end
endmodule

// File: doc/s2mm_ring_writer.md
S2MM_RING_WRITER -- requirements
Module: s2mm_ring_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 6, meaning AWID width.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning W and S_AXIS data width; legal values are 32 and 64.
REQ-004 SHALL have parameter BURST_LEN, default 16, meaning beats per burst; legal values are powers of 2 from 1 to 16.
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, meaning FIFO entries; it SHALL be a power of 2 and at least 2*BURST_LEN.
REQ-006 SHALL have the following ports, one per line: name, direction, width, meaning.
- aclk, in, 1, sole clock, rising edge.
- areset, in, 1, synchronous reset, active-high.
- enable, in, 1, capture and write enable.
- cfg_base, in, ADDR_WIDTH, ring base byte address, aligned to BURST_LEN*AXI_DATA_WIDTH/8.
- cfg_size, in, ADDR_WIDTH, ring size in bytes, a non-zero multiple of the burst byte count.
- wr_ptr, out, ADDR_WIDTH, byte offset of the next burst (committed data end).
- wrap_count, out, 16, number of ring wraps.
- overflow, out, 1, sticky: a sample was dropped.
- bresp_err, out, 1, sticky: a BRESP other than OKAY was received.
- busy, out, 1, FSM not in IDLE.
- S_AXIS_tready, out, 1.
- S_AXIS_tdata, in, AXI_DATA_WIDTH.
- S_AXIS_tvalid, in, 1.
- M_AXI_aw*: awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awcache[3:0], awprot[2:0], awuser[3:0], awvalid out; awready in.
- M_AXI_w*: wdata, wstrb, wlast, wvalid out; wready in.
- M_AXI_b*: bresp[1:0], bvalid in; bready out.

Function
REQ-007 SHALL drive constant AW fields: awid=0, awlen=BURST_LEN-1, awsize=log2(AXI_DATA_WIDTH/8), awburst=INCR, awcache=4'b0011, awprot=0, awuser=0, wstrb all ones.
REQ-008 SHALL drive S_AXIS_tready=enable; a beat is pushed when tvalid&enable&~fifo_full.
REQ-009 SHALL drop the beat and set overflow when tvalid&enable&fifo_full.
REQ-010 SHALL clear overflow, bresp_err, wr_ptr and wrap_count on the rising edge of enable (enable high, previous cycle low).
REQ-011 SHALL keep the FIFO count unchanged on a simultaneous push and pop; the count SHALL range from 0 to FIFO_DEPTH with no wrap.
REQ-012 SHALL implement the FSM states IDLE, ADDR, DATA and RESP.
REQ-013 SHALL move IDLE->ADDR when enable&(fifo_count>=BURST_LEN); awvalid SHALL then be asserted on the next cycle.
REQ-014 SHALL set awaddr=cfg_base+wr_ptr, held stable while awvalid is high.
REQ-015 SHALL move ADDR->DATA on awvalid&awready, and awvalid SHALL deassert in the same edge.
REQ-016 SHALL hold wvalid high throughout DATA; wdata is the FIFO head, first-word-fall-through, with zero cycles from FIFO head to wdata.
REQ-017 SHALL pop one FIFO entry and increment the beat counter on each wvalid&wready.
REQ-018 SHALL assert wlast exactly on beat BURST_LEN-1.
REQ-019 SHALL move DATA->RESP on wvalid&wready&wlast, and SHALL assert bready only in RESP.
REQ-020 SHALL, on bvalid in RESP, set bresp_err if bresp!=2'b00 and advance wr_ptr by BURST_LEN*AXI_DATA_WIDTH/8.
REQ-021 SHALL, on that bvalid, wrap wr_ptr to 0 and increment wrap_count (saturating at 16'hFFFF) if the advanced pointer is >= cfg_size.
REQ-022 SHALL, on that bvalid, go to ADDR if enable&(fifo_count>=BURST_LEN), else to IDLE.
REQ-023 SHALL complete a burst that is in progress when enable deasserts (ADDR, DATA or RESP) and then return to IDLE; the FIFO contents SHALL be retained.
REQ-024 SHALL never issue a partial burst; residual FIFO data below BURST_LEN SHALL stay in the FIFO.
REQ-025 SHALL leave behavior undefined for cfg_base and cfg_size changes while busy; the bench SHALL not change them while busy=1.

Reset
REQ-026 SHALL, while areset=1 at a clock edge, set: FSM=IDLE, FIFO empty, awvalid=0, wvalid=0, wlast=0, bready=0, wr_ptr=0, wrap_count=0, overflow=0, bresp_err=0, busy=0.
REQ-027 SHALL abort any burst in progress when reset is asserted mid-burst; no AXI handshake SHALL be issued in the cycle after reset is released.

Verification
REQ-028 SHALL pass this test: BURST_LEN=16, cfg_base=0x1000_0000, cfg_size=0x400, 32 beats streamed with awready and wready always high -> two bursts at 0x1000_0000 and 0x1000_0080, wlast on beats 15 and 31, wr_ptr=0x100.
REQ-029 SHALL pass this test: wrap, with cfg_size=0x100 and 4 bursts -> awaddr sequence 0x1000_0000, 0x1000_0080, 0x1000_0000, 0x1000_0080, wrap_count=2, wr_ptr=0.
REQ-030 SHALL pass this test: wready held low with tvalid continuous for FIFO_DEPTH+3 beats -> exactly 3 beats dropped, overflow=1, fifo_count=64.
REQ-031 SHALL pass this test: bresp=2'b10 on the first burst -> bresp_err=1 and the second burst still issued.
REQ-032 SHALL pass this test: enable dropped at beat 5 of a burst -> the remaining 11 beats complete, then IDLE with busy=0; areset asserted at beat 8 of a later burst -> all outputs at their reset values on the next edge.
REQ-033 SHALL pass this test: 10 beats streamed then enable held -> no AW issued, busy=0.
